mem_access_ctrl: RTL
====================

# mem_access_ctrl

MEM-stage data-memory access controller for the five-stage LoongArch pipeline. It accepts one operation per handshake from the EX→MEM boundary and sequences the load or store over a split-transaction data bus (address phase, then data phase). It formats store lanes and extracts and extends load data. It holds the operation until WB accepts the result, and supplies the MEM stage's ready-go behaviour that the pipeline register otherwise ties high.

## Interface
Parameters:
- none. Widths are fixed at 32-bit address and data.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  EX→MEM operation valid
- in_ready  out  1  controller can accept an operation
- in_re  in  1  operation is a load
- in_we  in  1  operation is a store (in_re and in_we are never both 1)
- in_size  in  2  access size: 00 byte, 01 half, 10 word
- in_sext  in  1  sign-extend load result
- in_addr  in  32  ALU result / effective address
- in_wdata  in  32  store data, right-aligned
- out_valid  out  1  result valid to WB
- out_ready  in  1  WB accepts result
- out_data  out  32  load data, or in_addr passthrough for non-memory ops
- out_ale  out  1  alignment exception for the held operation
- data_req  out  1  address-phase request
- data_wr  out  1  request is a write
- data_wstrb  out  4  byte write strobes
- data_addr  out  32  request address, passed through unmodified
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete (read data valid or write ack)
- data_rdata  in  32  read data

## Operation
- States: IDLE, REQ, WAIT, DONE. Operation fields are latched on accept (in_valid & in_ready).
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept of a non-memory op (in_re=in_we=0), or of a misaligned op when checking is enabled → DONE.
- Accept of a load or store → REQ.
- REQ:
  - data_req=1, with data_addr, data_wr, data_wstrb and data_wdata driven from latched fields and held stable until data_addr_ok.
  - data_addr_ok & data_data_ok in the same cycle → DONE.
  - data_addr_ok alone → WAIT.
- WAIT: data_data_ok → DONE. The read result is captured in the same cycle.
- DONE:
  - out_valid=1.
  - out_ready & in_valid → accept the new op, with the next state chosen per the new op.
  - out_ready & !in_valid → IDLE.
  - !out_ready → hold; out_data and out_ale are stable.
- Store lanes:
  - byte: wstrb = 0001<<addr[1:0], wdata = byte×4.
  - half: wstrb = 0011<<(2·addr[1]), wdata = half×2.
  - word: wstrb = 1111.
  - data_wstrb = 0000 for loads.
- Load extract: select the lane by addr[1:0]/addr[1], then zero- or sign-extend per in_sext.
- data_data_ok outside WAIT/REQ is ignored.
- Only one transaction is ever outstanding.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0, out_data=0, out_ale=0
  - data_req=0, data_wr=0, data_wstrb=0, data_addr=0, data_wdata=0
- Non-memory op: accepted at T, out_valid at T+1.
- Load/store with zero-wait slave: accepted at T, data_req at T+1 (addr_ok at T+1), data_ok at T+2, out_valid at T+3. With addr_ok and data_ok together at T+1, out_valid is at T+2.
- Back-to-back: in DONE with out_ready=1 and in_valid=1, the next op is accepted in the same cycle with no bubble.
- rst asserted in REQ/WAIT: return to IDLE and drop data_req next cycle. The late data_ok is then ignored.

## Configuration
- MEM_ALIGN_CHECK_EN defined:
  - half with addr[0]=1, or word with addr[1:0]≠0, sets out_ale=1.
  - No bus request is issued.
  - out_data = addr, and the op goes directly to DONE.
- Undefined:
  - out_ale is tied 0.
  - Misaligned accesses are issued, with lanes taken from the truncated address (half uses addr[1]; word ignores addr[1:0]).

## Structure
- Shared package: size encodings (SZ_B, SZ_H, SZ_W) and state enum constants.
- One sub-module, mem_lane_align: combinational strobe/wdata generation and load lane extract/extend, instantiated once.

## Test plan
- Non-memory op, addr=0x1234_5678, out_ready=1 → out_valid at T+1, out_data=0x1234_5678, data_req never asserted.
- Load byte sext, addr=0x...03, rdata=0x80FF_0000, addr_ok delayed 2 cycles → data_req held 3 cycles, out_data=0xFFFF_FF80.
- Store half, addr=0x...02, wdata=0x0000_ABCD → data_wstrb=1100, data_wdata=0xABCD_ABCD, data_wr=1, out_valid after data_ok.
- Load word, then WB stalls (out_ready=0) 4 cycles while in_valid=1 → in_ready=0, out_data stable; on release the next op is accepted same cycle.
- Load word at addr 0x...02 → with MEM_ALIGN_CHECK_EN: out_ale=1 at T+1, no data_req; without: data_req issued, out_ale=0.
- rst asserted during WAIT, data_ok arrives next cycle → state IDLE, out_valid stays 0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: access size encodings, controller states and the natural-alignment rule
package mem_access_ctrl_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SZ_B ? 1'b0 : size == SZ_H ? off[0] : |off;
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: EX->MEM operation, MEM->WB result and split-transaction data bus
interface mem_access_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_re;
  logic        in_we;
  logic [1:0]  in_size;
  logic        in_sext;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ale;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  modport master (
    input  in_valid, in_re, in_we, in_size, in_sext, in_addr, in_wdata, out_ready,
           data_addr_ok, data_data_ok, data_rdata,
    output in_ready, out_valid, out_data, out_ale, data_req, data_wr, data_wstrb,
           data_addr, data_wdata
  );
  modport slave (
    output in_valid, in_re, in_we, in_size, in_sext, in_addr, in_wdata, out_ready,
           data_addr_ok, data_data_ok, data_rdata,
    input  in_ready, out_valid, out_data, out_ale, data_req, data_wr, data_wstrb,
           data_addr, data_wdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: store strobe/lane replication and load lane extract with zero/sign extension
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wlane,
  output logic [31:0] rext
);
  logic [7:0]  rb;
  logic [15:0] rh;
  always_comb begin
    rb    = 8'(rdata >> {off, 3'b000});
    rh    = 16'(rdata >> {off[1], 4'b0000});
    strb  = size == SZ_B ? 4'b0001 << off : size == SZ_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wlane = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
    rext  = size == SZ_B ? {{24{sext & rb[7]}}, rb} : size == SZ_H ? {{16{sext & rh[15]}}, rh} : rdata;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store sequencer on a split-transaction bus; MEM_ALIGN_CHECK_EN traps misaligned half/word accesses
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst,
  mem_access_ctrl_if.master m
);
  state_t      state, nxt;
  logic        go, mis, cap, re_q, we_q, sext_q, ale_q;
  logic [1:0]  size_q;
  logic [3:0]  strb;
  logic [31:0] addr_q, wdata_q, data_q, rext, wlane;
`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (m.in_re | m.in_we) & misaligned(m.in_size, m.in_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign m.in_ready = state == S_IDLE || (state == S_DONE && m.out_ready);
  assign go  = m.in_valid & m.in_ready;
  // read data is captured on the data phase, whether it lands with the address phase or later
  assign cap = (state == S_REQ && m.data_addr_ok && m.data_data_ok) || (state == S_WAIT && m.data_data_ok);
  always_comb begin
    nxt = state;
    if (go) nxt = (!(m.in_re | m.in_we) || mis) ? S_DONE : S_REQ;
    else if (cap) nxt = S_DONE;
    else if (state == S_REQ && m.data_addr_ok) nxt = S_WAIT;
    else if (state == S_DONE && m.out_ready) nxt = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      ale_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        re_q    <= m.in_re;
        we_q    <= m.in_we;
        sext_q  <= m.in_sext;
        size_q  <= m.in_size;
        addr_q  <= m.in_addr;
        wdata_q <= m.in_wdata;
        data_q  <= m.in_addr;
        ale_q   <= mis;
      end else if (cap && re_q) data_q <= rext;
    end
  end
  mem_lane_align u_lane (
    .size (size_q),
    .off  (addr_q[1:0]),
    .sext (sext_q),
    .wdata(wdata_q),
    .rdata(m.data_rdata),
    .strb (strb),
    .wlane(wlane),
    .rext (rext)
  );
  assign m.out_valid  = state == S_DONE;
  assign m.out_data   = data_q;
  assign m.out_ale    = ale_q;
  assign m.data_req   = state == S_REQ;
  assign m.data_wr    = we_q;
  assign m.data_wstrb = we_q ? strb : 4'b0000;
  assign m.data_addr  = addr_q;
  assign m.data_wdata = wlane;
endmodule
